axistream_pack_arb: RTL

- Packet-granular round-robin arbiter that shares one axistream_pack instance (or any NUM_PACK-aligned consumer) among NUM_SRC AXI-Stream sources.
- Grant is held for a whole packet (through the tlast beat), so packets never interleave at the packer input.
- Counts beats per packet modulo NUM_PACK and flags tlast at a non-aligned beat, protecting the packer's alignment rule upstream of it.

---
 rtl/axistream_pack_arb_if.sv | 27 ++
 rtl/axistream_pack_arb.sv | 128 ++++++++++++
 2 files changed

// File: rtl/axistream_pack_arb_if.sv
// Bundled AXI-Stream signals around the packet arbiter: NUM_SRC source lanes in, one dest lane out.
// The arbiter uses the slave view; the source/packer environment uses the master view.
interface axistream_pack_arb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0]            src_tvalid;
    logic [NUM_SRC-1:0]            src_tready;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata;
    logic [NUM_SRC-1:0]            src_tlast;
    logic                          dest_tvalid;
    logic                          dest_tready;
    logic [DATA_WIDTH-1:0]         dest_tdata;
    logic                          dest_tlast;
    logic [ID_WIDTH-1:0]           dest_tid;

    modport slave (
        input  src_tvalid, src_tdata, src_tlast, dest_tready,
        output src_tready, dest_tvalid, dest_tdata, dest_tlast, dest_tid
    );

    modport master (
        output src_tvalid, src_tdata, src_tlast, dest_tready,
        input  src_tready, dest_tvalid, dest_tdata, dest_tlast, dest_tid
    );
endinterface

// File: rtl/axistream_pack_arb.sv
// Packet-granular round-robin arbiter feeding a NUM_PACK-aligned consumer; grant is held through tlast
// and a tlast on a beat that is not the last of a NUM_PACK group raises a one-cycle alignment error.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no owner; pick next requester round-robin after last_grant
// S_GRANT | r_grant owns dest until its tlast beat is accepted
module axistream_pack_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int NUM_PACK   = 4,
    parameter int ID_WIDTH   = $clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axistream_pack_arb_if.slave  bus,
    output logic                 busy,
    output logic                 tlast_align_err
);
    localparam int CNT_W = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PACK - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_last_grant;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic                  r_align_err;

    logic [ID_WIDTH-1:0]   w_winner;
    logic                  w_any_req;
    logic                  w_beat;
    logic                  w_gnt_valid;
    logic                  w_gnt_last;
    logic [DATA_WIDTH-1:0] w_gnt_data;

    // Scans downward so the last hit is the nearest index after 'last'.
    function automatic logic [ID_WIDTH-1:0] f_rr_pick(
        input logic [NUM_SRC-1:0]  req,
        input logic [ID_WIDTH-1:0] last
    );
        logic [ID_WIDTH-1:0] pick;
        logic [ID_WIDTH-1:0] idx;
        pick = last;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = ID_WIDTH'((int'(last) + k) % NUM_SRC);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign w_any_req = |bus.src_tvalid;
    assign w_winner  = f_rr_pick(bus.src_tvalid, r_last_grant);

    always_comb begin : gnt_mux
        w_gnt_valid = 1'b0;
        w_gnt_last  = 1'b0;
        w_gnt_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == ID_WIDTH'(i)) begin
                w_gnt_valid = bus.src_tvalid[i];
                w_gnt_last  = bus.src_tlast[i];
                w_gnt_data  = bus.src_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_beat = (r_state == S_GRANT) && w_gnt_valid && bus.dest_tready;

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin : next_state
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_GRANT;
            S_GRANT: if (w_beat && w_gnt_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : grant_regs
        if (!rst_n) begin
            r_last_grant <= ID_WIDTH'(NUM_SRC - 1);
            r_grant      <= '0;
            r_beat_cnt   <= '0;
            r_align_err  <= 1'b0;
        end else begin
            r_align_err <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_any_req) begin
                    r_grant      <= w_winner;
                    r_last_grant <= w_winner;
                    r_beat_cnt   <= '0;
                end
            end else if (w_beat) begin
                r_beat_cnt <= (r_beat_cnt == CNT_LAST) ? '0 : r_beat_cnt + 1'b1;
                if (w_gnt_last) r_align_err <= (r_beat_cnt != CNT_LAST);
            end
        end
    end

    // Combinational ready/valid path: no added latency per beat, dest_tvalid independent of dest_tready.
    always_comb begin : outputs
        busy            = 1'b0;
        bus.dest_tvalid = 1'b0;
        bus.dest_tlast  = 1'b0;
        bus.dest_tdata  = w_gnt_data;
        bus.dest_tid    = r_grant;
        bus.src_tready  = '0;
        tlast_align_err = r_align_err;
        if (r_state == S_GRANT) begin
            busy            = 1'b1;
            bus.dest_tvalid = w_gnt_valid;
            bus.dest_tlast  = w_gnt_last;
            for (int i = 0; i < NUM_SRC; i++) begin
                bus.src_tready[i] = bus.dest_tready && (r_grant == ID_WIDTH'(i));
            end
        end
    end
endmodule
